mc_control_unit: RTL

- Multi-cycle sequencer for the LEGv8 datapath.
- Replaces single-cycle decode with a registered FSM: FETCH / DECODE / EXEC / MEM / WB.
- Shares one unified instruction/data memory port that has a ready handshake.
- Drives the existing datapath controls (reg_2_loc, seu_op, alu_src, alu_op, mem_to_reg, reg_wr, pc_src, set_flags), plus IR/PC write enables and the address mux select.

---
 rtl/mc_control_unit_pkg.sv | 54 +++++
 rtl/mc_control_unit_op_class_decode.sv | 47 ++++
 rtl/mc_control_unit.sv | 130 +++++++++++++
 3 files changed

// File: rtl/mc_control_unit_pkg.sv
// Shared definitions for the LEGv8 multi-cycle control unit:
// FSM state encodings, instruction classes, alu_op / seu_op / pc_src codes,
// B.cond condition codes and the B.cond evaluation helper.
package mc_control_unit_pkg;

  typedef enum logic [2:0] {
    S_RESET, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_e;

  typedef enum logic [3:0] {
    C_R, C_I, C_LDUR, C_STUR, C_B, C_BCOND, C_CBZ, C_CBNZ, C_BR, C_ILLEGAL
  } op_class_e;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_ORR   = 3'b011;
  localparam logic [2:0] ALU_EOR   = 3'b100;
  localparam logic [2:0] ALU_LSL   = 3'b101;
  localparam logic [2:0] ALU_LSR   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  localparam logic [1:0] SEU_B  = 2'b00;
  localparam logic [1:0] SEU_CB = 2'b01;
  localparam logic [1:0] SEU_I  = 2'b10;
  localparam logic [1:0] SEU_D  = 2'b11;

  localparam logic [1:0] PC_SEQ = 2'b00;  // PC + 4
  localparam logic [1:0] PC_REL = 2'b01;  // old PC + extended offset
  localparam logic [1:0] PC_REG = 2'b10;  // register (BR)

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  // Only the six supported conditions can be taken; all others fall through.
  function automatic logic cond_taken(input logic [3:0] c, input logic eq, input logic ne,
                                      input logic ge, input logic lt, input logic gt,
                                      input logic le);
    case (c)
      COND_EQ: cond_taken = eq;
      COND_NE: cond_taken = ne;
      COND_GE: cond_taken = ge;
      COND_LT: cond_taken = lt;
      COND_GT: cond_taken = gt;
      COND_LE: cond_taken = le;
      default: cond_taken = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_unit_op_class_decode.sv
// op_class_decode: combinational LEGv8 opcode classifier.
// Ports: op_code[10:0] in (IR[31:21]); op_class out (instruction class);
//        is_s out (flag-setting variant); alu_fn out (ALU operation for R/I).
module op_class_decode
  import mc_control_unit_pkg::*;
(
  input  logic [10:0] op_code,
  output op_class_e   op_class,
  output logic        is_s,
  output logic [2:0]  alu_fn
);

  always_comb begin
    op_class = C_ILLEGAL;
    is_s     = 1'b0;
    alu_fn   = ALU_ADD;
    casez (op_code)
      11'b10001011000: op_class = C_R;                                          // ADD
      11'b10101011000: begin op_class = C_R; is_s = 1'b1; end                  // ADDS
      11'b11001011000: begin op_class = C_R; alu_fn = ALU_SUB; end             // SUB
      11'b11101011000: begin op_class = C_R; alu_fn = ALU_SUB; is_s = 1'b1; end // SUBS
      11'b10001010000: begin op_class = C_R; alu_fn = ALU_AND; end             // AND
      11'b11101010000: begin op_class = C_R; alu_fn = ALU_AND; is_s = 1'b1; end // ANDS
      11'b10101010000: begin op_class = C_R; alu_fn = ALU_ORR; end             // ORR
      11'b11001010000: begin op_class = C_R; alu_fn = ALU_EOR; end             // EOR
      11'b11010011011: begin op_class = C_R; alu_fn = ALU_LSL; end             // LSL
      11'b11010011010: begin op_class = C_R; alu_fn = ALU_LSR; end             // LSR
      11'b1001000100?: op_class = C_I;                                          // ADDI
      11'b1011000100?: begin op_class = C_I; is_s = 1'b1; end                  // ADDIS
      11'b1101000100?: begin op_class = C_I; alu_fn = ALU_SUB; end             // SUBI
      11'b1111000100?: begin op_class = C_I; alu_fn = ALU_SUB; is_s = 1'b1; end // SUBIS
      11'b1001001000?: begin op_class = C_I; alu_fn = ALU_AND; end             // ANDI
      11'b1111001000?: begin op_class = C_I; alu_fn = ALU_AND; is_s = 1'b1; end // ANDIS
      11'b1011001000?: begin op_class = C_I; alu_fn = ALU_ORR; end             // ORRI
      11'b1101001000?: begin op_class = C_I; alu_fn = ALU_EOR; end             // EORI
      11'b11111000010: op_class = C_LDUR;
      11'b11111000000: op_class = C_STUR;
      11'b11010110000: op_class = C_BR;
      11'b000101?????: op_class = C_B;
      11'b01010100???: op_class = C_BCOND;
      11'b10110100???: op_class = C_CBZ;
      11'b10110101???: op_class = C_CBNZ;
      default:         op_class = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle LEGv8 sequencer (FETCH/DECODE/EXEC/MEM/WB)
// sharing one instruction/data memory port with a ready handshake.
// Inputs : clk, reset (async, active high), op_code[10:0], cond[3:0],
//          zero/eq/ne/ge/lt/gt/le flags, mem_ready.
// Outputs: ir_wr, pc_wr, i_or_d, mem_rd, mem_wr, reg_2_loc, seu_op[1:0],
//          alu_src, alu_op[2:0], mem_to_reg, reg_wr, pc_src[1:0], set_flags,
//          halted, bus_err (sticky memory-timeout flag).
// Parameter MAX_WAIT (1..255): ready-low cycles tolerated in FETCH/MEM.
// Build option ILLEGAL_TRAP_EN: unrecognised opcodes halt instead of acting
// as a NOP.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] op_code,
  input  logic [3:0]  cond,
  input  logic        zero, eq, ne, ge, lt, gt, le,
  input  logic        mem_ready,
  output logic        ir_wr,
  output logic        pc_wr,
  output logic        i_or_d,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic        reg_2_loc,
  output logic [1:0]  seu_op,
  output logic        alu_src,
  output logic [2:0]  alu_op,
  output logic        mem_to_reg,
  output logic        reg_wr,
  output logic [1:0]  pc_src,
  output logic        set_flags,
  output logic        halted,
  output logic        bus_err
);

  state_e    state, next_state;
  logic [7:0] wait_cnt;
  op_class_e op_class;
  logic      is_s;
  logic [2:0] alu_fn;
  logic      mem_wait, timeout;

  op_class_decode u_dec (.op_code(op_code), .op_class(op_class), .is_s(is_s), .alu_fn(alu_fn));

  assign mem_wait = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
  // Ready arriving on the limit cycle wins: timeout needs ready still low.
  assign timeout  = mem_wait && (wait_cnt == 8'(MAX_WAIT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_RESET;
      wait_cnt <= 8'd0;
      bus_err  <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state != state) wait_cnt <= 8'd0;
      else if (mem_wait)       wait_cnt <= wait_cnt + 8'd1;
      if (timeout) bus_err <= 1'b1;
    end
  end

  always_comb begin
    next_state = state;
    ir_wr = 1'b0; pc_wr = 1'b0; i_or_d = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
    reg_2_loc = 1'b0; seu_op = SEU_B; alu_src = 1'b0; alu_op = ALU_ADD;
    mem_to_reg = 1'b0; reg_wr = 1'b0; pc_src = PC_SEQ; set_flags = 1'b0;
    halted = 1'b0;
    case (state)
      S_RESET: next_state = S_FETCH;
      S_FETCH: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          ir_wr = 1'b1; pc_wr = 1'b1; next_state = S_DECODE;
        end else if (timeout) next_state = S_HALT;
      end
      S_DECODE: begin
        reg_2_loc = (op_class inside {C_CBZ, C_CBNZ, C_BCOND, C_LDUR, C_STUR, C_BR});
        if (op_class != C_ILLEGAL) next_state = S_EXEC;
`ifdef ILLEGAL_TRAP_EN
        else next_state = S_HALT;
`else
        else next_state = S_FETCH;
`endif
      end
      S_EXEC: begin
        next_state = S_FETCH;
        case (op_class)
          C_R: begin
            alu_op = alu_fn; set_flags = is_s; next_state = S_WB;
          end
          C_I: begin
            seu_op = SEU_I; alu_src = 1'b1; alu_op = alu_fn; set_flags = is_s;
            next_state = S_WB;
          end
          C_LDUR, C_STUR: begin
            seu_op = SEU_D; alu_src = 1'b1; next_state = S_MEM;
          end
          C_B:  begin pc_wr = 1'b1; pc_src = PC_REL; end
          C_BR: begin pc_wr = 1'b1; pc_src = PC_REG; end
          C_CBZ, C_CBNZ: begin
            seu_op = SEU_CB; alu_op = ALU_PASSB; pc_src = PC_REL;
            pc_wr  = (op_class == C_CBZ) ? zero : !zero;
          end
          C_BCOND: begin
            seu_op = SEU_CB; pc_src = PC_REL;
            pc_wr  = cond_taken(cond, eq, ne, ge, lt, gt, le);
          end
          default: ;
        endcase
      end
      S_MEM: begin
        // Address path held stable until the memory accepts the access.
        i_or_d = 1'b1; alu_src = 1'b1; seu_op = SEU_D;
        if (op_class == C_LDUR) mem_rd = 1'b1;
        else                    mem_wr = 1'b1;
        if (mem_ready)    next_state = (op_class == C_LDUR) ? S_WB : S_FETCH;
        else if (timeout) next_state = S_HALT;
      end
      S_WB: begin
        reg_wr = 1'b1; mem_to_reg = (op_class == C_LDUR); next_state = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: next_state = S_RESET;
    endcase
  end

endmodule
